// File: rtl/reg_read_pkg.sv
// Shared defaults and requester indices for the register-bank read arbiter.
// Included by the arbiter top and its round-robin sub-module.
package reg_read_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 4;
    localparam bit DEF_ZERO_REG = 1'b1;

    localparam int REQ_DECODE = 0;
    localparam int REQ_DEBUG  = 1;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a sole eligible requester always wins, a tie goes
// to the requester the rr pointer favours, and the pointer then moves to the loser.
module rr_arbiter2
    import reg_read_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] eligible,
    output logic [1:0] grant
);

    logic rr_q;
    logic rr_d;

    always_comb begin
        grant = 2'b00;
        rr_d  = rr_q;
        if (eligible[REQ_DECODE] && eligible[REQ_DEBUG]) begin
            grant[rr_q] = 1'b1;
        end else begin
            grant = eligible;
        end
        if (grant[REQ_DECODE]) begin
            rr_d = 1'b1;
        end else if (grant[REQ_DEBUG]) begin
            rr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/reg_read_arbiter.sv
// Arbitrates decode/debug read requests onto the bank's single combinational
// read port and returns registered, write-forwarded snapshots per requester.
module reg_read_arbiter
    import reg_read_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = DEF_ZERO_REG
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data0,
    output logic [DATA_W-1:0] rsp_data1,
    input  logic [1:0]        rsp_ready,
    output logic [ADDR_W-1:0] bank_rd_addr,
    input  logic [DATA_W-1:0] bank_rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    function automatic logic [DATA_W-1:0] capture_val(
        input logic [ADDR_W-1:0] addr,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic [DATA_W-1:0] rdata
    );
        if (ZERO_REG && (addr == '0)) begin
            return '0;
        end else if (we && (waddr == addr)) begin
            return wdata;
        end else begin
            return rdata;
        end
    endfunction

    slot_state_e       slot_q [2];
    slot_state_e       slot_d [2];
    logic [DATA_W-1:0] data_q [2];
    logic [DATA_W-1:0] data_d [2];

    logic [1:0]        slot_free;
    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic [DATA_W-1:0] cap_data;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rsp_valid[i] = (slot_q[i] == RSP_FULL);
        end
    end

    // Reset gating keeps req_ready low while reset_n is asserted.
    assign slot_free = ~rsp_valid | rsp_ready;
    assign eligible  = req_valid & slot_free & {2{reset_n}};
    assign req_ready = grant;

    rr_arbiter2 u_rr (
        .clk      (clk),
        .reset_n  (reset_n),
        .eligible (eligible),
        .grant    (grant)
    );

    assign bank_rd_addr = grant[REQ_DEBUG] ? req_addr1 : req_addr0;
    assign cap_data     = capture_val(bank_rd_addr, wr_en, wr_addr, wr_data, bank_rd_data);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            slot_d[i] = slot_q[i];
            data_d[i] = data_q[i];
            if (grant[i]) begin
                slot_d[i] = RSP_FULL;
                data_d[i] = cap_data;
            end else if (rsp_ready[i]) begin
                slot_d[i] = RSP_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= RSP_EMPTY;
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= slot_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign rsp_data0 = data_q[REQ_DECODE];
    assign rsp_data1 = data_q[REQ_DEBUG];

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Directed bench for reg_read_arbiter: a vector table for arbitration, forwarding
// and hold behaviour, plus hand sequences for reset and async reset mid-flight.
module tb_reg_read_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [3:0]  req_addr0;
    logic [3:0]  req_addr1;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_data0;
    logic [15:0] rsp_data1;
    logic [1:0]  rsp_ready;
    logic [3:0]  bank_rd_addr;
    logic [15:0] bank_rd_data;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;

    logic [15:0] bank [16];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign bank_rd_data = bank[bank_rd_addr];

    reg_read_arbiter #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_addr0    (req_addr0),
        .req_addr1    (req_addr1),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data0    (rsp_data0),
        .rsp_data1    (rsp_data1),
        .rsp_ready    (rsp_ready),
        .bank_rd_addr (bank_rd_addr),
        .bank_rd_data (bank_rd_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data)
    );

    typedef struct {
        logic [1:0]  rv;
        logic [3:0]  a0;
        logic [3:0]  a1;
        logic [1:0]  rr;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  e_rdy;
        logic [3:0]  e_addr;
        logic [1:0]  e_rv;
        logic [15:0] e_d0;
        logic [15:0] e_d1;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] rv, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [1:0] rr, input logic we, input logic [3:0] wa,
                         input logic [15:0] wd);
        req_valid = rv;
        req_addr0 = a0;
        req_addr1 = a1;
        rsp_ready = rr;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
    endtask

    // Clock edge plus the bank's own write, as the real register bank would do.
    task automatic tick();
        @(posedge clk);
        if (wr_en) bank[wr_addr] = wr_data;
        #1;
    endtask

    function automatic vec_t mk(input logic [1:0] rv, input logic [3:0] a0, input logic [3:0] a1,
                                input logic [1:0] rr, input logic we, input logic [3:0] wa,
                                input logic [15:0] wd, input logic [1:0] e_rdy,
                                input logic [3:0] e_addr, input logic [1:0] e_rv,
                                input logic [15:0] e_d0, input logic [15:0] e_d1);
        vec_t v;
        v.rv = rv; v.a0 = a0; v.a1 = a1; v.rr = rr; v.we = we; v.wa = wa; v.wd = wd;
        v.e_rdy = e_rdy; v.e_addr = e_addr; v.e_rv = e_rv; v.e_d0 = e_d0; v.e_d1 = e_d1;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = 16'h0000;
        bank[0] = 16'hFFFF;
        bank[3] = 16'hAAAA;
        bank[4] = 16'hBBBB;
        bank[5] = 16'h1234;

        //            rv     a0     a1     rr     we    wa     wd        rdy    addr   rv     d0        d1
        vecs[0]  = mk(2'b00, 4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 16'h0000, 2'b00, 4'd0, 2'b00, 16'h0000, 16'h0000);
        vecs[1]  = mk(2'b01, 4'd5, 4'd0, 2'b00, 1'b0, 4'd0, 16'h0000, 2'b01, 4'd5, 2'b01, 16'h1234, 16'h0000);
        vecs[2]  = mk(2'b00, 4'd0, 4'd0, 2'b01, 1'b0, 4'd0, 16'h0000, 2'b00, 4'd0, 2'b00, 16'h1234, 16'h0000);
        vecs[3]  = mk(2'b10, 4'd0, 4'd4, 2'b11, 1'b0, 4'd0, 16'h0000, 2'b10, 4'd4, 2'b10, 16'h1234, 16'hBBBB);
        vecs[4]  = mk(2'b11, 4'd3, 4'd4, 2'b11, 1'b0, 4'd0, 16'h0000, 2'b01, 4'd3, 2'b01, 16'hAAAA, 16'hBBBB);
        vecs[5]  = mk(2'b11, 4'd3, 4'd4, 2'b11, 1'b0, 4'd0, 16'h0000, 2'b10, 4'd4, 2'b10, 16'hAAAA, 16'hBBBB);
        vecs[6]  = mk(2'b11, 4'd3, 4'd4, 2'b11, 1'b0, 4'd0, 16'h0000, 2'b01, 4'd3, 2'b01, 16'hAAAA, 16'hBBBB);
        vecs[7]  = mk(2'b11, 4'd3, 4'd4, 2'b11, 1'b0, 4'd0, 16'h0000, 2'b10, 4'd4, 2'b10, 16'hAAAA, 16'hBBBB);
        vecs[8]  = mk(2'b10, 4'd0, 4'd7, 2'b11, 1'b1, 4'd7, 16'hBEEF, 2'b10, 4'd7, 2'b10, 16'hAAAA, 16'hBEEF);
        vecs[9]  = mk(2'b01, 4'd0, 4'd0, 2'b11, 1'b1, 4'd0, 16'h5555, 2'b01, 4'd0, 2'b01, 16'h0000, 16'hBEEF);
        vecs[10] = mk(2'b01, 4'd5, 4'd0, 2'b01, 1'b0, 4'd0, 16'h0000, 2'b01, 4'd5, 2'b01, 16'h1234, 16'hBEEF);
        vecs[11] = mk(2'b01, 4'd5, 4'd0, 2'b00, 1'b1, 4'd5, 16'h9999, 2'b00, 4'd5, 2'b01, 16'h1234, 16'hBEEF);
        vecs[12] = mk(2'b01, 4'd5, 4'd0, 2'b01, 1'b0, 4'd0, 16'h0000, 2'b01, 4'd5, 2'b01, 16'h9999, 16'hBEEF);
        vecs[13] = mk(2'b11, 4'd3, 4'd4, 2'b11, 1'b0, 4'd0, 16'h0000, 2'b10, 4'd4, 2'b10, 16'h9999, 16'hBBBB);

        // Power-on reset with requests pending: nothing may be accepted.
        reset_n = 1'b0;
        drive(2'b11, 4'd3, 4'd4, 2'b00, 1'b0, 4'd0, 16'h0000);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data0", 32'(rsp_data0), 32'h0);
        chk("reset_rsp_data1", 32'(rsp_data1), 32'h0);
        tick();
        tick();
        drive(2'b00, 4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 16'h0000);
        #2 reset_n = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rv, vecs[i].a0, vecs[i].a1, vecs[i].rr, vecs[i].we, vecs[i].wa, vecs[i].wd);
            #1;
            chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_bank_rd_addr", i), 32'(bank_rd_addr), 32'(vecs[i].e_addr));
            tick();
            chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_rsp_data0", i), 32'(rsp_data0), 32'(vecs[i].e_d0));
            chk($sformatf("v%0d_rsp_data1", i), 32'(rsp_data1), 32'(vecs[i].e_d1));
        end

        // Fill both slots, then assert reset between edges.
        drive(2'b01, 4'd3, 4'd0, 2'b00, 1'b0, 4'd0, 16'h0000);
        #1;
        chk("fill_req_ready", 32'(req_ready), 32'h1);
        tick();
        chk("fill_rsp_valid", 32'(rsp_valid), 32'h3);
        chk("fill_rsp_data0", 32'(rsp_data0), 32'hAAAA);
        drive(2'b11, 4'd3, 4'd4, 2'b00, 1'b0, 4'd0, 16'h0000);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("async_rsp_data0", 32'(rsp_data0), 32'h0);
        chk("async_rsp_data1", 32'(rsp_data1), 32'h0);
        chk("async_req_ready", 32'(req_ready), 32'h0);
        tick();
        drive(2'b00, 4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 16'h0000);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_reset_idle%0d", i), 32'(rsp_valid), 32'h0);
        end

        // rr was 1 before reset; a tie now must go to requester 0.
        drive(2'b11, 4'd3, 4'd4, 2'b00, 1'b0, 4'd0, 16'h0000);
        #1;
        chk("post_reset_tie_grant", 32'(req_ready), 32'h1);
        tick();
        chk("post_reset_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("post_reset_rsp_data0", 32'(rsp_data0), 32'hAAAA);
        drive(2'b00, 4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 16'h0000);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_read_arbiter.md
Name: reg_read_arbiter

Overview:
- Read-side companion to the 16-bit register bank.
- Accepts read requests from two requesters over valid/ready handshakes: port 0 is decode, port 1 is debug.
- Arbitrates them onto the bank's single combinational read port and returns registered 16-bit responses.
- Forwards same-cycle bank writes, so readers never see stale data.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 4, register address width (16 entries).
- ZERO_REG, 1, when 1 a read of address 0 returns 0 regardless of bank contents.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  2  per-requester read request valid.
- req_addr0  input  ADDR_W  requester 0 address.
- req_addr1  input  ADDR_W  requester 1 address.
- req_ready  output  2  per-requester request accepted this cycle.
- rsp_valid  output  2  per-requester response valid.
- rsp_data0  output  DATA_W  requester 0 response data.
- rsp_data1  output  DATA_W  requester 1 response data.
- rsp_ready  input  2  per-requester response consumed.
- bank_rd_addr  output  ADDR_W  address driven to the bank read port.
- bank_rd_data  input  DATA_W  combinational bank read data.
- wr_en  input  1  bank write snoop: enable.
- wr_addr  input  ADDR_W  bank write snoop: address.
- wr_data  input  DATA_W  bank write snoop: data.

Behaviour:
- Reset (reset_n=0, async):
  - rsp_valid=0, rsp_data0=rsp_data1=0.
  - Round-robin pointer rr=0 (requester 0 favoured).
  - req_ready=0 while in reset.
- Per-requester slot state is RSP_EMPTY or RSP_FULL, mirrored by rsp_valid[i].
- slot_free[i] = !rsp_valid[i] || rsp_ready[i]. Back-to-back reads at 1/cycle are possible when the consumer holds rsp_ready.
- Eligible[i] = req_valid[i] && slot_free[i].
- Grant rules:
  - Exactly one eligible requester: it is granted.
  - Both eligible: requester rr is granted.
  - req_ready[i] = grant[i]. This is combinational from req_valid/rsp_ready; requesters must not make req_valid depend on req_ready.
  - rr update on any grant: rr <= ~granted index. It is unchanged when nothing is granted.
- bank_rd_addr:
  - Equals the granted requester's address.
  - With no grant, it equals req_addr0.
- Captured value for a grant on cycle N, in priority order:
  1. 0 if ZERO_REG && addr==0.
  2. Else wr_data if wr_en && wr_addr==addr (write-first bypass).
  3. Else bank_rd_data.
- Latency: grant on cycle N gives rsp_valid[i]=1 and rsp_data updated from cycle N+1.
- Hold: while rsp_valid[i] && !rsp_ready[i], rsp_data[i] is frozen.
  - The response is a snapshot; a later write to the same address does not alter it.
- Slot transitions:
  - rsp_ready[i] && no new grant: slot -> EMPTY.
  - rsp_ready[i] && new grant: slot stays FULL with new data.
- rsp_ready while rsp_valid=0 is ignored.
- Simultaneous wr_en to address 0 with ZERO_REG=1 still returns 0.
- Reset asserted mid-transaction discards pending responses; no response is emitted after release until a new grant.
- Requester 1 never starves: after it loses a tie, rr points to it.

Decomposition:
- Package reg_read_pkg holds:
  - DATA_W and ADDR_W defaults.
  - Requester index constants REQ_DECODE=0 and REQ_DEBUG=1.
  - The ZERO_REG default.
- Sub-module rr_arbiter2 (2-way round-robin, reset_n async): inputs eligible[1:0]; outputs grant[1:0]; owns the rr flop.
- The response slot is duplicated inline; no separate module.

Test Plan:
1. Reset, then bank[5]=0x1234. Assert req_valid=01, addr0=5 for one cycle -> req_ready=01 that cycle; next cycle rsp_valid=01, rsp_data0=0x1234.
2. Both requesters valid, addr0=3 (0xAAAA), addr1=4 (0xBBBB), rsp_ready=11, held 4 cycles -> grants alternate 0,1,0,1. Responses arrive one cycle after each grant with the matching data.
3. Same-cycle write wr_en=1, wr_addr=7, wr_data=0xBEEF while requester 1 is granted addr 7 (bank still 0x0000) -> rsp_data1=0xBEEF.
4. With ZERO_REG=1, read addr 0 while bank[0]=0xFFFF and wr_en to addr 0 -> rsp_data0=0x0000.
5. rsp_ready0=0 with rsp_valid0=1 and req_valid0=1 -> req_ready0=0 and rsp_data0 holds. A write to the same address is not reflected. Raising rsp_ready0 grants the next request in that same cycle.
6. Pending rsp_valid=11, then pulse reset_n low mid-cycle -> rsp_valid=00 immediately (async). After release, rr=0 and no spurious response appears.
